// File: rtl/spi_controller_if.sv
// Request/response and SPI pin bundle for spi_controller.
// slave modport: controller view (request in, status + SPI pins out, CIPO in).
// master modport: requester/environment view (drives request fields and CIPO).
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic       CIPO;

  modport slave (
    input  start, rw, addr, wdata, CIPO,
    output busy, done, rdata, SCLK, COPI, nCS
  );

  modport master (
    output start, rw, addr, wdata, CIPO,
    input  busy, done, rdata, SCLK, COPI, nCS
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit frame {rw, addr[6:0], wdata[7:0]} MSB first per start.
// Latency: done at 1+CS_SETUP+32*CLK_DIV+CS_HOLD+IDLE_GAP cycles after accept (137 with defaults).
// Backpressure: start is only sampled in IDLE; while busy=1 further requests are dropped.
// Ports: clk, rst (sync, active-high); bus.slave carries start/rw/addr/wdata in,
//        busy/done/rdata status out, SCLK/COPI/nCS pins out and asynchronous CIPO in.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_controller_if.slave  bus
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [3:0]    bit_q, bit_n;
  logic [15:0]   frame_q, frame_n;
  logic [7:0]    shreg_q, shreg_n;
  logic          sclk_q, sclk_n;
  logic          copi_q, copi_n;
  logic          ncs_q, ncs_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [7:0]    rdata_q, rdata_n;

  // CIPO comes from another clock domain; two flops before it is used.
  logic cipo_meta_q, cipo_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cipo_meta_q <= 1'b0;
      cipo_sync_q <= 1'b0;
    end else begin
      cipo_meta_q <= bus.CIPO;
      cipo_sync_q <= cipo_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      frame_q <= frame_n;
      shreg_q <= shreg_n;
      sclk_q  <= sclk_n;
      copi_q  <= copi_n;
      ncs_q   <= ncs_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      rdata_q <= rdata_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    frame_n = frame_q;
    shreg_n = shreg_q;
    sclk_n  = sclk_q;
    copi_n  = copi_q;
    ncs_n   = ncs_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    rdata_n = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Frame is captured here so later changes on rw/addr/wdata are ignored.
          frame_n = {bus.rw, bus.addr, bus.wdata};
          state_n = SETUP;
          cnt_n   = '0;
          bit_n   = 4'd15;
          ncs_n   = 1'b0;
          busy_n  = 1'b1;
          copi_n  = bus.rw;
          sclk_n  = 1'b0;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_n = '0;
          if (!sclk_q) begin
            sclk_n = 1'b1;
          end else begin
            // End of a high phase: SCLK falls and COPI advances in the same cycle,
            // giving a full half-period of setup and hold around each rising edge.
            sclk_n = 1'b0;
            if (bit_q <= 4'd7) begin
              shreg_n = {shreg_q[6:0], cipo_sync_q};
            end
            if (bit_q == 4'd0) begin
              state_n = HOLD;
              copi_n  = 1'b0;
            end else begin
              bit_n  = bit_q - 4'd1;
              copi_n = frame_q[bit_q - 4'd1];
            end
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          ncs_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          // The done cycle is spent in IDLE, so a pending start is taken right away.
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          rdata_n = shreg_q;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.SCLK  = sclk_q;
  assign bus.COPI  = copi_q;
  assign bus.nCS   = ncs_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a register-file peripheral model on the SPI pins.
// Cycle numbering: c0 is the tb cycle count at the first negedge after the accepting edge
// (the cycle where nCS first reads low); done is then expected at c0+136.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller_if bus();

  spi_controller #(
    .CLK_DIV (4),
    .CS_SETUP(2),
    .CS_HOLD (2),
    .IDLE_GAP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Frame capture at SCLK rising edges; cleared when nCS falls.
  logic [15:0] cap   = '0;
  int          rises = 0;
  always @(posedge bus.SCLK or negedge bus.nCS) begin
    if (bus.SCLK) begin
      if (!bus.nCS) begin
        cap   <= {cap[14:0], bus.COPI};
        rises <= rises + 1;
      end
    end else begin
      cap   <= '0;
      rises <= 0;
    end
  end

  // Peripheral read data: bit idx presented after the falling edge that starts it.
  logic [7:0] rbyte = '0;
  always @(negedge bus.SCLK or negedge bus.nCS) begin
    int idx;
    idx = 15 - rises;
    if (!bus.nCS && idx >= 0 && idx <= 7) bus.CIPO = rbyte[idx];
    else bus.CIPO = 1'b0;
  end

  // Peripheral register file: a full 16-bit write frame commits on nCS rising.
  logic [7:0] en_reg_out_7_0  = '0;
  logic [7:0] en_reg_out_15_8 = '0;
  logic [7:0] en_reg_pwm_7_0  = '0;
  logic [7:0] en_reg_pwm_15_8 = '0;
  logic [7:0] pwm_duty_cycle  = '0;
  always @(posedge bus.nCS) begin
    if (rises == 16 && cap[15]) begin
      case (cap[14:8])
        7'd0: en_reg_out_7_0  <= cap[7:0];
        7'd1: en_reg_out_15_8 <= cap[7:0];
        7'd2: en_reg_pwm_7_0  <= cap[7:0];
        7'd3: en_reg_pwm_15_8 <= cap[7:0];
        7'd4: pwm_duty_cycle  <= cap[7:0];
        default: ;
      endcase
    end
  end

  task automatic start_frame(input logic rw_i, input logic [6:0] a, input logic [7:0] d,
                             output int c0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.rw    = rw_i;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int limit, output bit found, output int dcyc,
                           output int last_low);
    int n;
    found = 1'b0;
    dcyc = 0;
    last_low = 0;
    n = 0;
    while (!found && n < limit) begin
      @(negedge clk);
      n++;
      if (!bus.nCS) last_low = cyc;
      if (bus.done) begin
        found = 1'b1;
        dcyc = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    checks++; if (bus.SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", bus.SCLK); end
    checks++; if (bus.COPI !== 1'b0) begin errors++; $display("FAIL reset_copi got=%b exp=0", bus.COPI); end
    checks++; if (bus.nCS !== 1'b1) begin errors++; $display("FAIL reset_ncs got=%b exp=1", bus.nCS); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    int c0, dcyc, last_low;
    bit found;
    rbyte = 8'h00;
    start_frame(1'b1, 7'h00, 8'hA5, c0);
    checks++; if (bus.nCS !== 1'b0) begin errors++; $display("FAIL wr_ncs_low got=%b exp=0", bus.nCS); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.COPI !== 1'b1) begin errors++; $display("FAIL wr_copi_first got=%b exp=1", bus.COPI); end
    wait_done(300, found, dcyc, last_low);
    checks++;
    if (!found) begin
      errors++; $display("FAIL wr_done_timeout got=none exp=pulse");
    end else begin
      checks++; if (dcyc - c0 !== 136) begin errors++; $display("FAIL wr_done_time got=%0d exp=136", dcyc - c0); end
      checks++; if (last_low - c0 !== 131) begin errors++; $display("FAIL wr_ncs_last_low got=%0d exp=131", last_low - c0); end
      checks++; if (rises !== 16) begin errors++; $display("FAIL wr_sclk_rises got=%0d exp=16", rises); end
      checks++; if (cap !== 16'h80A5) begin errors++; $display("FAIL wr_frame got=%h exp=80a5", cap); end
      checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata got=%h exp=00", bus.rdata); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_done got=%b exp=0", bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wr_done_width got=%b exp=0", bus.done); end
    end
  endtask

  task automatic test_read;
    int c0, dcyc, last_low;
    bit found;
    rbyte = 8'h3C;
    start_frame(1'b0, 7'h04, 8'h00, c0);
    wait_done(300, found, dcyc, last_low);
    checks++;
    if (!found) begin
      errors++; $display("FAIL rd_done_timeout got=none exp=pulse");
    end else begin
      checks++; if (cap !== 16'h0400) begin errors++; $display("FAIL rd_frame got=%h exp=0400", cap); end
      checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata got=%h exp=3c", bus.rdata); end
      repeat (5) @(negedge clk);
      checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata_hold got=%h exp=3c", bus.rdata); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] fr [3];
    int c0_prev, dprev, lprev, c0, dcyc, last_low, n;
    bit found;
    fr[0] = 16'h81FF; fr[1] = 16'h8200; fr[2] = 16'h8380;
    dprev = 0; lprev = 0; c0_prev = 0;
    rbyte = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    bus.rw = fr[0][15]; bus.addr = fr[0][14:8]; bus.wdata = fr[0][7:0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      found = 1'b0;
      while (!found && n < 20) begin
        @(negedge clk);
        n++;
        if (bus.busy) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL b2b_accept_timeout frame=%0d got=idle exp=busy", k);
        bus.start = 1'b0;
        return;
      end
      c0 = cyc;
      if (k < 2) begin
        bus.rw = fr[k+1][15]; bus.addr = fr[k+1][14:8]; bus.wdata = fr[k+1][7:0];
      end else begin
        bus.start = 1'b0;
      end
      if (k > 0) begin
        checks++;
        if ((c0 - lprev - 1) < 5) begin errors++; $display("FAIL b2b_ncs_gap frame=%0d got=%0d exp>=5", k, c0 - lprev - 1); end
      end
      wait_done(300, found, dcyc, last_low);
      checks++;
      if (!found) begin
        errors++; $display("FAIL b2b_done_timeout frame=%0d got=none exp=pulse", k);
        bus.start = 1'b0;
        return;
      end
      checks++; if (cap !== fr[k]) begin errors++; $display("FAIL b2b_frame frame=%0d got=%h exp=%h", k, cap, fr[k]); end
      if (k > 0) begin
        checks++;
        if (dcyc - dprev !== 137) begin errors++; $display("FAIL b2b_done_spacing frame=%0d got=%0d exp=137", k, dcyc - dprev); end
      end
      dprev = dcyc; lprev = last_low; c0_prev = c0;
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_fourth got=%b exp=0", bus.busy); end
  endtask

  task automatic test_busy_ignore;
    int c0, dcyc, last_low;
    bit found, extra;
    start_frame(1'b1, 7'h00, 8'hA5, c0);
    bus.wdata = 8'h00;
    while (cyc < c0 + 19) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(300, found, dcyc, last_low);
    checks++;
    if (!found) begin
      errors++; $display("FAIL ign_done_timeout got=none exp=pulse");
    end else begin
      checks++; if (cap !== 16'h80A5) begin errors++; $display("FAIL ign_frame got=%h exp=80a5", cap); end
      checks++; if (dcyc - c0 !== 136) begin errors++; $display("FAIL ign_done_time got=%0d exp=136", dcyc - c0); end
      extra = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (bus.busy || !bus.nCS) extra = 1'b1;
      end
      checks++; if (extra !== 1'b0) begin errors++; $display("FAIL ign_second_frame got=%b exp=0", extra); end
    end
  endtask

  task automatic test_reset_mid;
    int c0, dcyc, last_low;
    bit found, seen_done;
    rbyte = 8'h5A;
    start_frame(1'b1, 7'h01, 8'h55, c0);
    while (cyc < c0 + 62) @(negedge clk);
    checks++; if (rises !== 8 || bus.SCLK !== 1'b1) begin errors++; $display("FAIL mid_position got=rises%0d/sclk%b exp=rises8/sclk1", rises, bus.SCLK); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.nCS !== 1'b1) begin errors++; $display("FAIL mid_ncs got=%b exp=1", bus.nCS); end
    checks++; if (bus.SCLK !== 1'b0) begin errors++; $display("FAIL mid_sclk got=%b exp=0", bus.SCLK); end
    checks++; if (bus.COPI !== 1'b0) begin errors++; $display("FAIL mid_copi got=%b exp=0", bus.COPI); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    seen_done = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got=%b exp=0", seen_done); end
    start_frame(1'b1, 7'h01, 8'h55, c0);
    wait_done(300, found, dcyc, last_low);
    checks++;
    if (!found) begin
      errors++; $display("FAIL mid_after_timeout got=none exp=pulse");
    end else begin
      checks++; if (cap !== 16'h8155) begin errors++; $display("FAIL mid_after_frame got=%h exp=8155", cap); end
      checks++; if (dcyc - c0 !== 136) begin errors++; $display("FAIL mid_after_time got=%0d exp=136", dcyc - c0); end
      checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL mid_after_rdata got=%h exp=5a", bus.rdata); end
    end
  endtask

  task automatic test_loopback;
    int c0, dcyc, last_low;
    bit found;
    rbyte = 8'h00;
    start_frame(1'b1, 7'h04, 8'h80, c0);
    wait_done(300, found, dcyc, last_low);
    checks++; if (!found) begin errors++; $display("FAIL lb_w4_timeout got=none exp=pulse"); end
    checks++; if (pwm_duty_cycle !== 8'h80) begin errors++; $display("FAIL lb_pwm_duty got=%h exp=80", pwm_duty_cycle); end
    start_frame(1'b1, 7'h00, 8'hF0, c0);
    wait_done(300, found, dcyc, last_low);
    checks++; if (!found) begin errors++; $display("FAIL lb_w0_timeout got=none exp=pulse"); end
    checks++; if (en_reg_out_7_0 !== 8'hF0) begin errors++; $display("FAIL lb_out_7_0 got=%h exp=f0", en_reg_out_7_0); end
    start_frame(1'b1, 7'h06, 8'h11, c0);
    wait_done(300, found, dcyc, last_low);
    checks++; if (!found) begin errors++; $display("FAIL lb_w6_timeout got=none exp=pulse"); end
    // Earlier tests left addr1=55 (reset test), addr2=00 and addr3=80 (back-to-back frames).
    checks++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'hF0_55_00_80_80) begin
      errors++;
      $display("FAIL lb_addr6_unchanged got=%h_%h_%h_%h_%h exp=f0_55_00_80_80",
               en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
